// File: rtl/excp_commit.sv
// -----------------------------------------------------------------------------
// excp_commit -- commit-side trap sequencer in front of the CSR file.
//
// Watches the oldest retiring instruction. When it carries an exception (ERTN
// included) or the CSR interrupt level is high at the moment of commit, the
// trap is recorded, outstanding memory traffic is drained, the CSR trap
// interface is driven for exactly one cycle and the CSR-supplied target PC is
// handed to fetch through a valid/ready redirect handshake.
//
// Ports
//   clk, resetn                    clock, asynchronous active-low reset
//   commit_valid/commit_ready      commit handshake (ready only while idle)
//   commit_pc, commit_excp*        retiring instruction and its exception tag
//   commit_badv*, commit_vppn_vld  faulting address and TLB-related flag
//   interrupt                      CSR interrupt level, sampled at commit only
//   mem_busy                       memory traffic still outstanding
//   raise_excp, excp_type, pc_in   CSR trap interface (one-cycle pulse)
//   badv_we/badv_data              BADV update
//   vppn_we/vppn_data              TLB VPPN update (badv[31:13])
//   csr_pc_out                     CSR trap/ERTN target, combinational
//   flush                          kill younger pipeline state
//   redirect_valid/pc/ready        new fetch PC handshake
//   trap_count                     wrapping count of raise_excp pulses
// -----------------------------------------------------------------------------
package excp_commit_pkg;

    // {Ecode, EsubCode} as seen by the CSR file.
    typedef struct packed {
        logic [5:0] ecode;
        logic [8:0] esubcode;
    } excp_t;

    localparam excp_t EXCP_INT  = {6'h00, 9'h000};
    // ERTN is not an architectural exception; it borrows an otherwise unused
    // EsubCode under Ecode 0 so the CSR file can tell it apart from INT.
    localparam excp_t EXCP_ERTN = {6'h00, 9'h001};
    localparam excp_t EXCP_ADEF = {6'h08, 9'h000};
    localparam excp_t EXCP_ALE  = {6'h09, 9'h000};
    localparam excp_t EXCP_TLBR = {6'h3F, 9'h000};

endpackage

module excp_commit
    import excp_commit_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             commit_valid,
    output logic             commit_ready,
    input  logic [31:0]      commit_pc,
    input  logic             commit_excp,
    input  excp_t            commit_excp_type,
    input  logic             commit_badv_vld,
    input  logic [31:0]      commit_badv,
    input  logic             commit_vppn_vld,
    input  logic             interrupt,
    input  logic             mem_busy,
    output logic             raise_excp,
    output excp_t            excp_type,
    output logic [31:0]      pc_in,
    output logic             badv_we,
    output logic [31:0]      badv_data,
    output logic             vppn_we,
    output logic [18:0]      vppn_data,
    input  logic [31:0]      csr_pc_out,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    input  logic             redirect_ready,
    output logic [CNT_W-1:0] trap_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        RAISE = 2'd2,
        REDIR = 2'd3
    } state_t;

    // VPPN is the 8 KiB-page-aligned part of the faulting address.
    function automatic logic [18:0] f_vppn(input logic [31:0] addr);
        return addr[31:13];
    endfunction

    state_t            r_state;
    excp_t             r_rec_type;
    logic [31:0]       r_rec_pc;
    logic [31:0]       r_rec_badv;
    logic              r_rec_badv_vld;
    logic              r_rec_vppn_vld;

    logic              r_commit_ready;
    logic              r_raise_excp;
    excp_t             r_excp_type;
    logic [31:0]       r_pc_in;
    logic              r_badv_we;
    logic [31:0]       r_badv_data;
    logic              r_vppn_we;
    logic [18:0]       r_vppn_data;
    logic              r_flush;
    logic              r_redirect_valid;
    logic [31:0]       r_redirect_pc;
    logic [CNT_W-1:0]  r_trap_count;

    logic              w_fire;
    logic              w_take;
    excp_t             w_rec_type;
    logic              w_rec_badv_vld;
    logic              w_rec_vppn_vld;

    assign w_fire = commit_valid && r_commit_ready;
    assign w_take = interrupt || commit_excp;

    // Trap record contents: a pending interrupt wins over any exception and
    // carries no address side effects.
    always_comb begin
        w_rec_type     = EXCP_INT;
        w_rec_badv_vld = 1'b0;
        w_rec_vppn_vld = 1'b0;
        if (interrupt) begin
            w_rec_type     = EXCP_INT;
            w_rec_badv_vld = 1'b0;
            w_rec_vppn_vld = 1'b0;
        end else begin
            w_rec_type     = commit_excp_type;
            w_rec_badv_vld = commit_badv_vld && (commit_excp_type != EXCP_ERTN);
            w_rec_vppn_vld = commit_vppn_vld;
        end
    end

    // Trap sequencer: state, trap record and every registered output.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state          <= IDLE;
            r_rec_type       <= EXCP_INT;
            r_rec_pc         <= 32'h0000_0000;
            r_rec_badv       <= 32'h0000_0000;
            r_rec_badv_vld   <= 1'b0;
            r_rec_vppn_vld   <= 1'b0;
            r_commit_ready   <= 1'b0;
            r_raise_excp     <= 1'b0;
            r_excp_type      <= EXCP_INT;
            r_pc_in          <= 32'h0000_0000;
            r_badv_we        <= 1'b0;
            r_badv_data      <= 32'h0000_0000;
            r_vppn_we        <= 1'b0;
            r_vppn_data      <= 19'h0_0000;
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'h0000_0000;
            r_trap_count     <= {CNT_W{1'b0}};
        end else begin
            // CSR trap strobes are single-cycle; excp_type deliberately holds.
            r_raise_excp <= 1'b0;
            r_pc_in      <= 32'h0000_0000;
            r_badv_we    <= 1'b0;
            r_badv_data  <= 32'h0000_0000;
            r_vppn_we    <= 1'b0;
            r_vppn_data  <= 19'h0_0000;
            r_flush      <= 1'b0;

            case (r_state)
                IDLE: begin
                    // commit_ready comes up one cycle after reset release.
                    if (w_fire && w_take) begin
                        r_rec_type     <= w_rec_type;
                        r_rec_pc       <= commit_pc;
                        r_rec_badv     <= commit_badv;
                        r_rec_badv_vld <= w_rec_badv_vld;
                        r_rec_vppn_vld <= w_rec_vppn_vld;
                        r_commit_ready <= 1'b0;
                        r_state        <= DRAIN;
                    end else begin
                        r_commit_ready <= 1'b1;
                        r_state        <= IDLE;
                    end
                end
                DRAIN: begin
                    if (!mem_busy) begin
                        r_raise_excp <= 1'b1;
                        r_excp_type  <= r_rec_type;
                        r_pc_in      <= r_rec_pc;
                        r_badv_we    <= r_rec_badv_vld;
                        r_badv_data  <= r_rec_badv;
                        r_vppn_we    <= r_rec_vppn_vld;
                        r_vppn_data  <= f_vppn(r_rec_badv);
                        r_flush      <= 1'b1;
                        r_state      <= RAISE;
                    end else begin
                        r_state      <= DRAIN;
                    end
                end
                RAISE: begin
                    // csr_pc_out still reflects pre-trap CSR state here.
                    r_redirect_pc    <= csr_pc_out;
                    r_redirect_valid <= 1'b1;
                    r_trap_count     <= r_trap_count + CNT_W'(1);
                    r_state          <= REDIR;
                end
                REDIR: begin
                    if (redirect_ready) begin
                        r_redirect_valid <= 1'b0;
                        r_commit_ready   <= 1'b1;
                        r_state          <= IDLE;
                    end else begin
                        r_redirect_valid <= 1'b1;
                        r_state          <= REDIR;
                    end
                end
                default: begin
                    r_redirect_valid <= 1'b0;
                    r_commit_ready   <= 1'b0;
                    r_state          <= IDLE;
                end
            endcase
        end
    end

    assign commit_ready   = r_commit_ready;
    assign raise_excp     = r_raise_excp;
    assign excp_type      = r_excp_type;
    assign pc_in          = r_pc_in;
    assign badv_we        = r_badv_we;
    assign badv_data      = r_badv_data;
    assign vppn_we        = r_vppn_we;
    assign vppn_data      = r_vppn_data;
    assign flush          = r_flush;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign trap_count     = r_trap_count;

endmodule

// File: tb/tb_excp_commit.sv
// -----------------------------------------------------------------------------
// tb_excp_commit -- self-checking bench for excp_commit.
// A small CSR model supplies csr_pc_out. Each trap is described at transaction
// level (what was committed, how long memory stays busy, how long fetch stalls)
// and the expected CSR pulse, redirect and counter values follow from the trap
// rules. The counter is built 4 bits wide so wrap-around is reachable.
// -----------------------------------------------------------------------------
module tb_excp_commit;
    import excp_commit_pkg::*;

    localparam int          CW        = 4;
    localparam logic [31:0] EENTRY    = 32'h1C00_8000;
    localparam logic [31:0] TLBRENTRY = 32'h1C00_C000;
    localparam logic [31:0] ERA       = 32'h1C00_0200;

    logic          clk = 1'b0;
    logic          resetn;
    logic          commit_valid, commit_ready;
    logic [31:0]   commit_pc;
    logic          commit_excp;
    excp_t         commit_excp_type;
    logic          commit_badv_vld;
    logic [31:0]   commit_badv;
    logic          commit_vppn_vld;
    logic          interrupt, mem_busy;
    logic          raise_excp;
    excp_t         excp_type;
    logic [31:0]   pc_in;
    logic          badv_we;
    logic [31:0]   badv_data;
    logic          vppn_we;
    logic [18:0]   vppn_data;
    logic [31:0]   csr_pc_out;
    logic          flush, redirect_valid, redirect_ready;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] trap_count;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    // CSR model: target PC depends only on the presented trap type.
    always_comb begin
        if (excp_type == EXCP_ERTN)      csr_pc_out = ERA;
        else if (excp_type == EXCP_TLBR) csr_pc_out = TLBRENTRY;
        else                             csr_pc_out = EENTRY;
    end

    excp_commit #(.CNT_W(CW)) dut (
        .clk(clk), .resetn(resetn),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_pc(commit_pc), .commit_excp(commit_excp),
        .commit_excp_type(commit_excp_type),
        .commit_badv_vld(commit_badv_vld), .commit_badv(commit_badv),
        .commit_vppn_vld(commit_vppn_vld), .interrupt(interrupt),
        .mem_busy(mem_busy), .raise_excp(raise_excp), .excp_type(excp_type),
        .pc_in(pc_in), .badv_we(badv_we), .badv_data(badv_data),
        .vppn_we(vppn_we), .vppn_data(vppn_data), .csr_pc_out(csr_pc_out),
        .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
        .trap_count(trap_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (commit_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_ready", {31'd0, commit_ready}, 32'd1);
    endtask

    // Garbage on the commit bus after fire proves the record was latched;
    // interrupt wiggles must be ignored outside IDLE.
    task automatic scramble();
        commit_valid     = 1'b0;
        commit_pc        = $urandom;
        commit_excp      = 1'($urandom_range(0, 1));
        commit_excp_type = 15'($urandom);
        commit_badv_vld  = 1'($urandom_range(0, 1));
        commit_badv      = $urandom;
        commit_vppn_vld  = 1'($urandom_range(0, 1));
        interrupt        = 1'($urandom_range(0, 1));
    endtask

    task automatic plain_commit(input logic [31:0] pc);
        wait_ready();
        commit_valid = 1'b1; commit_pc = pc; commit_excp = 1'b0;
        interrupt = 1'b0; commit_badv_vld = 1'b0; commit_vppn_vld = 1'b0;
        @(negedge clk);
        scramble();
        interrupt = 1'b0;
        chk("plain_ready", {31'd0, commit_ready}, 32'd1);
        chk("plain_raise", {31'd0, raise_excp}, 32'd0);
        chk("plain_cnt", {28'd0, trap_count}, exp_cnt);
    endtask

    task automatic run_trap(input logic [31:0] pc, input logic ex, input excp_t ty,
                            input logic bv, input logic [31:0] badv, input logic vv,
                            input logic intr, input int busy, input int rdly);
        excp_t       et;
        logic        ebw, evw;
        logic [31:0] epc;
        et  = intr ? EXCP_INT : ty;
        ebw = !intr && bv && (ty != EXCP_ERTN);
        evw = !intr && vv;
        epc = (et == EXCP_ERTN) ? ERA : ((et == EXCP_TLBR) ? TLBRENTRY : EENTRY);
        wait_ready();
        commit_valid = 1'b1; commit_pc = pc; commit_excp = ex;
        commit_excp_type = ty; commit_badv_vld = bv; commit_badv = badv;
        commit_vppn_vld = vv; interrupt = intr;
        mem_busy = 1'($urandom_range(0, 1));
        redirect_ready = 1'b0;
        @(negedge clk);
        scramble();
        chk("drain_ready", {31'd0, commit_ready}, 32'd0);
        chk("drain_raise", {31'd0, raise_excp}, 32'd0);
        for (int i = 0; i < busy; i++) begin
            mem_busy = 1'b1;
            @(negedge clk);
            chk("busy_ready", {31'd0, commit_ready}, 32'd0);
            chk("busy_raise", {31'd0, raise_excp}, 32'd0);
        end
        mem_busy = 1'b0;
        @(negedge clk);
        chk("raise", {31'd0, raise_excp}, 32'd1);
        chk("excp_type", {17'd0, excp_type}, {17'd0, et});
        chk("pc_in", pc_in, pc);
        chk("badv_we", {31'd0, badv_we}, {31'd0, ebw});
        if (ebw) chk("badv_data", badv_data, badv);
        chk("vppn_we", {31'd0, vppn_we}, {31'd0, evw});
        if (evw) chk("vppn_data", {13'd0, vppn_data}, {13'd0, badv[31:13]});
        chk("flush", {31'd0, flush}, 32'd1);
        chk("raise_ready", {31'd0, commit_ready}, 32'd0);
        chk("raise_rvalid", {31'd0, redirect_valid}, 32'd0);
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        @(negedge clk);
        for (int w = 0; w <= rdly; w++) begin
            chk("redir_valid", {31'd0, redirect_valid}, 32'd1);
            chk("redir_pc", redirect_pc, epc);
            chk("redir_raise", {31'd0, raise_excp}, 32'd0);
            chk("redir_flush", {31'd0, flush}, 32'd0);
            chk("redir_ready", {31'd0, commit_ready}, 32'd0);
            redirect_ready = (w == rdly);
            @(negedge clk);
        end
        redirect_ready = 1'b0;
        chk("done_rvalid", {31'd0, redirect_valid}, 32'd0);
        chk("done_ready", {31'd0, commit_ready}, 32'd1);
        chk("done_cnt", {28'd0, trap_count}, exp_cnt);
    endtask

    initial begin
        excp_t rty;
        int    sel;
        resetn = 1'b0; commit_valid = 1'b0; commit_pc = 32'h0; commit_excp = 1'b0;
        commit_excp_type = EXCP_INT; commit_badv_vld = 1'b0; commit_badv = 32'h0;
        commit_vppn_vld = 1'b0; interrupt = 1'b0; mem_busy = 1'b0;
        redirect_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, commit_ready}, 32'd0);
        chk("rst_raise", {31'd0, raise_excp}, 32'd0);
        chk("rst_type", {17'd0, excp_type}, 32'd0);
        chk("rst_rvalid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_cnt", {28'd0, trap_count}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // ADEF, no drain
        run_trap(32'h1C00_0100, 1'b1, EXCP_ADEF, 1'b1, 32'h1C00_0102, 1'b0, 1'b0, 0, 0);
        // TLBR with VPPN update
        run_trap(32'h1C00_0300, 1'b1, EXCP_TLBR, 1'b1, 32'h0040_3ABC, 1'b1, 1'b0, 0, 1);
        // interrupt beats ALE
        run_trap(32'h1C00_0400, 1'b1, EXCP_ALE, 1'b1, 32'h0000_1001, 1'b1, 1'b1, 0, 0);
        // memory busy for 5 cycles
        run_trap(32'h1C00_0500, 1'b1, EXCP_ALE, 1'b1, 32'h0000_2003, 1'b0, 1'b0, 5, 0);
        // ERTN, fetch stalls 3 cycles
        run_trap(32'h1C00_0600, 1'b1, EXCP_ERTN, 1'b1, 32'h0000_3000, 1'b0, 1'b0, 0, 3);
        plain_commit(32'h1C00_0700);

        // reset in the middle of DRAIN abandons the trap
        wait_ready();
        commit_valid = 1'b1; commit_pc = 32'h1C00_0800; commit_excp = 1'b1;
        commit_excp_type = EXCP_ADEF; interrupt = 1'b0;
        @(negedge clk);
        scramble();
        mem_busy = 1'b1;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("mid_rst_raise", {31'd0, raise_excp}, 32'd0);
        chk("mid_rst_ready", {31'd0, commit_ready}, 32'd0);
        chk("mid_rst_flush", {31'd0, flush}, 32'd0);
        chk("mid_rst_pc_in", pc_in, 32'd0);
        chk("mid_rst_cnt", {28'd0, trap_count}, 32'd0);
        exp_cnt = 0;
        @(negedge clk);
        resetn = 1'b1; mem_busy = 1'b0; interrupt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_raise", {31'd0, raise_excp}, 32'd0);
        end

        // random traps interleaved with plain commits; 15 traps reach all-ones
        for (int n = 0; n < 15; n++) begin
            if ($urandom_range(0, 2) == 0) plain_commit($urandom & 32'hFFFF_FFFC);
            sel = $urandom_range(0, 3);
            case (sel)
                0:       rty = EXCP_ADEF;
                1:       rty = EXCP_ALE;
                2:       rty = EXCP_TLBR;
                default: rty = EXCP_ERTN;
            endcase
            run_trap($urandom & 32'hFFFF_FFFC, 1'b1, rty,
                     1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0), $urandom_range(0, 3),
                     $urandom_range(0, 2));
        end
        chk("cnt_all_ones", {28'd0, trap_count}, 32'd15);
        run_trap(32'h1C00_0900, 1'b1, EXCP_ALE, 1'b0, 32'h0, 1'b0, 1'b0, 1, 0);
        chk("cnt_wrap", {28'd0, trap_count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
